// File: rtl/cpu_run_ctrl_if.sv
// Board-side signal bundle of the run/step/check controller:
// pushbuttons, rate switch and halt in; clock enable and display data out.
interface cpu_run_ctrl_if;
    logic       key_run_n;
    logic       key_step_n;
    logic       key_check_n;
    logic       SW_choose;
    logic       halt;
    logic       cpu_ce;
    logic       light_clk;
    logic [1:0] State;
    logic [7:0] check_addr;

    modport master (
        output key_run_n, key_step_n, key_check_n, SW_choose, halt,
        input  cpu_ce, light_clk, State, check_addr
    );

    modport slave (
        input  key_run_n, key_step_n, key_check_n, SW_choose, halt,
        output cpu_ce, light_clk, State, check_addr
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/check controller: key debounce, CPU state, rate-divided
// clock enable and a free-running display refresh clock.
module cpu_run_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int FAST_DIV  = 5000000,
    parameter int SLOW_DIV  = 25000000,
    parameter int LIGHT_DIV = 25000
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        RUN   = 2'b01,
        CHECK = 2'b10,
        STEP  = 2'b11
    } state_t;

    localparam int MAXDIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int DBW    = $clog2(DB_CYCLES + 1);
    localparam int RW     = $clog2(MAXDIV + 1);
    localparam int LW     = $clog2(LIGHT_DIV + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [RW-1:0]  FAST_LAST  = RW'(FAST_DIV - 1);
    localparam logic [RW-1:0]  SLOW_LAST  = RW'(SLOW_DIV - 1);
    localparam logic [LW-1:0]  LIGHT_LAST = LW'(LIGHT_DIV - 1);

    // bit order: 3=SW_choose 2=check 1=step 0=run; keys idle high
    localparam logic [3:0] SYNC_IDLE = 4'b0111;

    logic [3:0]     raw, sync1, sync2;
    logic [2:0]     lvl, press;
    logic [DBW-1:0] db_cnt [3];
    logic           run_ev, check_ev, step_ev;
    state_t         state, state_d;
    logic [7:0]     addr, addr_d;
    logic [RW-1:0]  rcnt;
    logic           rate_hit, ce;
    logic [LW-1:0]  lcnt;
    logic           light;

    assign raw = {bus.SW_choose, bus.key_check_n,
                  bus.key_step_n, bus.key_run_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= 3'b111;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    lvl[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // press fires on the cycle the low level becomes accepted
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++)
            press[i] = ~sync2[i] & lvl[i] & (db_cnt[i] == DB_LAST);
    end

    assign run_ev   = press[0];
    assign check_ev = press[2] & ~press[0];
    assign step_ev  = press[1] & ~press[0] & ~press[2];

    assign rate_hit = rcnt >= (sync2[3] ? FAST_LAST : SLOW_LAST);

    always_comb begin
        state_d = state;
        addr_d  = addr;
        ce      = 1'b0;
        unique case (state)
            STOP: begin
                if (run_ev) begin
                    state_d = RUN;
                end else if (check_ev) begin
                    state_d = CHECK;
                    addr_d  = 8'h00;
                end else if (step_ev) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                ce      = 1'b1;
                state_d = STOP;
            end
            RUN: begin
                ce = rate_hit & ~bus.halt;
                if (bus.halt || run_ev) state_d = STOP;
            end
            CHECK: begin
                if (run_ev) state_d = STOP;
                else if (check_ev) addr_d = addr + 8'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOP;
            addr  <= 8'h00;
        end else begin
            state <= state_d;
            addr  <= addr_d;
        end
    end

    // counter only advances while RUN persists; any entry starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else if (state == RUN && state_d == RUN) begin
            rcnt <= rate_hit ? '0 : rcnt + RW'(1);
        end else begin
            rcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt  <= '0;
            light <= 1'b0;
        end else if (lcnt == LIGHT_LAST) begin
            lcnt  <= '0;
            light <= ~light;
        end else begin
            lcnt <= lcnt + LW'(1);
        end
    end

    assign bus.cpu_ce     = ce;
    assign bus.light_clk  = light;
    assign bus.State      = state;
    assign bus.check_addr = addr;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed key sequences plus random key bounce,
// checked every cycle against a sample-history model of the controller.
module tb_cpu_run_ctrl;

    localparam int DB    = 4;
    localparam int FAST  = 8;
    localparam int SLOW  = 20;
    localparam int LIGHT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .DB_CYCLES(DB),
        .FAST_DIV (FAST),
        .SLOW_DIV (SLOW),
        .LIGHT_DIV(LIGHT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ce_cnt = 0;
    bit saw_step = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // index 0=run 1=step 2=check 3=SW_choose
    logic [3:0]    m_s1, m_s2;
    logic [DB-1:0] m_hist [3];
    logic [2:0]    m_acc;
    int            m_st, m_addr, m_rate, m_edges;

    always @(posedge clk or negedge rst_n) begin : model
        logic [DB-1:0] hn;
        logic [2:0]    ev;
        logic [2:0]    acc_n;
        int            st, addr, rate, div;
        bit            due;
        if (!rst_n) begin
            m_s1    <= 4'b0111;
            m_s2    <= 4'b0111;
            for (int k = 0; k < 3; k++) m_hist[k] <= '1;
            m_acc   <= 3'b111;
            m_st    <= 0;
            m_addr  <= 0;
            m_rate  <= 0;
            m_edges <= 0;
        end else begin
            ev    = '0;
            acc_n = m_acc;
            for (int k = 0; k < 3; k++) begin
                hn = {m_hist[k][DB-2:0], m_s2[k]};
                m_hist[k] <= hn;
                // last DB synchronised samples all disagree with accepted level
                if (hn == {DB{~m_acc[k]}}) begin
                    acc_n[k] = ~m_acc[k];
                    ev[k]    = m_acc[k];
                end
            end
            div  = m_s2[3] ? FAST : SLOW;
            due  = (m_st == 1) && (m_rate >= div - 1);
            st   = m_st;
            addr = m_addr;
            rate = 0;
            case (m_st)
                0: begin
                    if (ev[0]) st = 1;
                    else if (ev[2]) begin st = 2; addr = 0; end
                    else if (ev[1]) st = 3;
                end
                3: st = 0;
                1: begin
                    if (bus.halt || ev[0]) st = 0;
                    else rate = due ? 0 : m_rate + 1;
                end
                default: begin
                    if (ev[0]) st = 0;
                    else if (ev[2]) addr = (m_addr + 1) % 256;
                end
            endcase
            m_acc   <= acc_n;
            m_st    <= st;
            m_addr  <= addr;
            m_rate  <= rate;
            m_s2    <= m_s1;
            m_s1    <= {bus.SW_choose, bus.key_check_n,
                        bus.key_step_n, bus.key_run_n};
            m_edges <= m_edges + 1;
        end
    end

    function automatic int exp_ce();
        int div;
        div = m_s2[3] ? FAST : SLOW;
        return int'((m_st == 3) ||
                     (m_st == 1 && m_rate >= div - 1 && !bus.halt));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("State", int'(bus.State), m_st);
        check("check_addr", int'(bus.check_addr), m_addr);
        check("cpu_ce", int'(bus.cpu_ce), exp_ce());
        check("light_clk", int'(bus.light_clk), (m_edges / LIGHT) % 2);
        if (bus.cpu_ce) ce_cnt <= ce_cnt + 1;
        if (bus.State == 2'b11) saw_step <= 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: bus.key_run_n = v;
            1: bus.key_step_n = v;
            default: bus.key_check_n = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b0);
        cyc_wait(6);
        set_key(k, 1'b1);
        cyc_wait(8);
    endtask

    task automatic wait_pulse(output int at, input int limit);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_timeout: no cpu_ce within %0d cycles", limit);
        end
    endtask

    task automatic light_rise(output int at);
        logic prev;
        at = -1;
        @(negedge clk);
        prev = bus.light_clk;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!prev && bus.light_clk) begin
                at = cyc;
                break;
            end
            prev = bus.light_clk;
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL light_timeout: no light_clk rise in 20 cycles");
        end
    endtask

    initial begin
        int c0, t0, t1, t2, t3, t4;
        bus.key_run_n   = 1'b1;
        bus.key_step_n  = 1'b1;
        bus.key_check_n = 1'b1;
        bus.SW_choose   = 1'b1;
        bus.halt        = 1'b0;
        #2 rst_n = 1'b0;
        cyc_wait(3);
        check("rst_State", int'(bus.State), 0);
        check("rst_ce", int'(bus.cpu_ce), 0);
        check("rst_addr", int'(bus.check_addr), 0);
        check("rst_light", int'(bus.light_clk), 0);
        rst_n = 1'b1;
        cyc_wait(2);

        // STEP held 10 clks: one pulse through STEP
        c0 = ce_cnt;
        saw_step = 1'b0;
        bus.key_step_n = 1'b0;
        cyc_wait(10);
        bus.key_step_n = 1'b1;
        cyc_wait(10);
        check("step_pulses", ce_cnt - c0, 1);
        check("step_seen", int'(saw_step), 1);
        check("step_back_stop", int'(bus.State), 0);

        // 2-clk glitch is filtered
        c0 = ce_cnt;
        bus.key_step_n = 1'b0;
        cyc_wait(2);
        bus.key_step_n = 1'b1;
        cyc_wait(10);
        check("glitch_pulses", ce_cnt - c0, 0);

        // RUN at fast rate; first pulse on the eighth RUN cycle
        bus.key_run_n = 1'b0;
        cyc_wait(6);
        bus.key_run_n = 1'b1;
        @(negedge clk);
        check("run_entry", int'(bus.State), 1);
        t0 = cyc;
        wait_pulse(t1, 40);
        check("first_pulse", t1 - t0, FAST - 1);
        wait_pulse(t2, 40);
        check("fast_spacing", t2 - t1, FAST);
        cyc_wait(3);
        bus.SW_choose = 1'b0;
        wait_pulse(t3, 60);
        wait_pulse(t4, 60);
        check("slow_spacing", t4 - t3, SLOW);

        // halt on the cycle a pulse is due
        cyc_wait(SLOW);
        bus.halt = 1'b1;
        @(negedge clk);
        check("halt_no_ce", int'(bus.cpu_ce), 0);
        cyc_wait(1);
        bus.halt = 1'b0;
        @(negedge clk);
        check("halt_stop", int'(bus.State), 0);
        cyc_wait(2);

        // CHECK entry and full address wrap
        press(2);
        check("check_entry", int'(bus.State), 2);
        check("check_addr0", int'(bus.check_addr), 0);
        for (int i = 0; i < 255; i++) press(2);
        check("check_addrFF", int'(bus.check_addr), 8'hFF);
        press(2);
        check("check_wrap", int'(bus.check_addr), 0);
        press(1);
        check("check_step_ign", int'(bus.State), 2);
        press(2);
        press(0);
        check("check_run_stop", int'(bus.State), 0);
        check("check_addr_held", int'(bus.check_addr), 1);

        // simultaneous RUN and STEP from STOP
        saw_step = 1'b0;
        bus.key_run_n  = 1'b0;
        bus.key_step_n = 1'b0;
        cyc_wait(6);
        bus.key_run_n  = 1'b1;
        bus.key_step_n = 1'b1;
        cyc_wait(8);
        check("prio_run", int'(bus.State), 1);
        check("prio_no_step", int'(saw_step), 0);
        press(0);
        check("run_toggle_stop", int'(bus.State), 0);

        // reset mid-RUN with a non-zero address
        press(2);
        press(2);
        press(2);
        press(0);
        press(0);
        check("pre_rst_run", int'(bus.State), 1);
        check("pre_rst_addr", int'(bus.check_addr), 2);
        cyc_wait(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_State", int'(bus.State), 0);
        check("mid_rst_ce", int'(bus.cpu_ce), 0);
        check("mid_rst_addr", int'(bus.check_addr), 0);
        cyc_wait(3);
        rst_n = 1'b1;
        light_rise(t1);
        light_rise(t2);
        check("light_period", t2 - t1, 2 * LIGHT);

        // random keys with bounce, rate switch and halt
        for (int i = 0; i < 400; i++) begin
            bus.key_run_n   = ($urandom_range(0, 5) != 0);
            bus.key_step_n  = ($urandom_range(0, 2) != 0);
            bus.key_check_n = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) bus.SW_choose = ~bus.SW_choose;
            bus.halt = ($urandom_range(0, 11) == 0);
            cyc_wait($urandom_range(1, 8));
        end
        bus.key_run_n   = 1'b1;
        bus.key_step_n  = 1'b1;
        bus.key_check_n = 1'b1;
        bus.halt        = 1'b0;
        cyc_wait(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
